// File: rtl/reg_array.sv
// Small register file: DEPTH x DATA_WIDTH entries, synchronous write port and
// combinational read port sharing one address; every entry is cleared by reset.
module reg_array #(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           ADDR_WIDTH  = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= RESET_VALUE;
    end else if (we) begin
      mem[addr] <= data_in;
    end
  end

  // Read straight from storage: no forwarding of data_in ahead of the edge.
  assign data_out = mem[addr];

endmodule

// File: tb/tb_reg_array.sv
// Self-checking bench for reg_array: directed vector table, async-reset
// sequences, and randomized traffic against an array-based reference model.
module tb_reg_array;

  logic       clk;
  logic       rst_n;
  logic       we;
  logic [1:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int tests  = 0;
  int errors = 0;

  logic [7:0] model [4];

  reg_array #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (2),
    .RESET_VALUE(8'h00)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       we;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] exp_before;
    logic [7:0] exp_after;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    vecs[0]  = '{"wr0_11",   1'b1, 2'd0, 8'h11, 8'h00, 8'h11};
    vecs[1]  = '{"wr1_22",   1'b1, 2'd1, 8'h22, 8'h00, 8'h22};
    vecs[2]  = '{"wr2_33",   1'b1, 2'd2, 8'h33, 8'h00, 8'h33};
    vecs[3]  = '{"rd0",      1'b0, 2'd0, 8'hFF, 8'h11, 8'h11};
    vecs[4]  = '{"rd1",      1'b0, 2'd1, 8'hFF, 8'h22, 8'h22};
    vecs[5]  = '{"rd2",      1'b0, 2'd2, 8'hFF, 8'h33, 8'h33};
    vecs[6]  = '{"rd3",      1'b0, 2'd3, 8'hFF, 8'h00, 8'h00};
    vecs[7]  = '{"nowe1_a",  1'b0, 2'd1, 8'hFF, 8'h22, 8'h22};
    vecs[8]  = '{"nowe1_b",  1'b0, 2'd1, 8'hFF, 8'h22, 8'h22};
    vecs[9]  = '{"nowe1_c",  1'b0, 2'd1, 8'hFF, 8'h22, 8'h22};
    vecs[10] = '{"ovr0_a5",  1'b1, 2'd0, 8'hA5, 8'h11, 8'hA5};
    vecs[11] = '{"wr3_44",   1'b1, 2'd3, 8'h44, 8'h00, 8'h44};
    vecs[12] = '{"after_r0", 1'b0, 2'd0, 8'h00, 8'hA5, 8'hA5};
    vecs[13] = '{"after_r1", 1'b0, 2'd1, 8'h00, 8'h22, 8'h22};
    vecs[14] = '{"after_r2", 1'b0, 2'd2, 8'h00, 8'h33, 8'h33};

    rst_n = 1'b0; we = 1'b0; addr = '0; data_in = '0;

    // Reset held: sweep every address, including across a clock edge with we=1.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      addr = 2'(i); we = 1'b1; data_in = 8'h5A;
      #1 check("reset_sweep", data_out, 8'h00);
    end
    @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      we = vecs[i].we; addr = vecs[i].addr; data_in = vecs[i].din;
      #1 check({vecs[i].name, "_before"}, data_out, vecs[i].exp_before);
      @(posedge clk);
      #1 check({vecs[i].name, "_after"}, data_out, vecs[i].exp_after);
    end

    // Async reset mid-run: pulse between edges with addr 3 (holds 44).
    @(negedge clk);
    we = 1'b0; addr = 2'd3;
    #1 check("pre_async_rst", data_out, 8'h44);
    #1 rst_n = 1'b0;
    #1 check("async_rst_immediate", data_out, 8'h00);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #0.5 addr = 2'(i);
      #0.1 check("post_rst_sweep", data_out, 8'h00);
    end

    // Writes during reset are discarded; first write after release lands.
    @(negedge clk);
    rst_n = 1'b0; we = 1'b1; addr = 2'd2; data_in = 8'h77;
    @(posedge clk);
    #1 check("write_in_reset", data_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1; data_in = 8'h99;
    #1 check("release_no_bypass", data_out, 8'h00);
    @(posedge clk);
    #1 check("first_write_after_rel", data_out, 8'h99);
    @(negedge clk);
    we = 1'b0;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    model[2] = 8'h99;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      we = 1'($urandom_range(0, 1));
      addr = 2'($urandom_range(0, 3));
      data_in = 8'($urandom);
      #1 check("rand_before", data_out, model[addr]);
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = 8'h00;
        #1 check("rand_async_rst", data_out, 8'h00);
        #1 rst_n = 1'b1;
      end
      @(posedge clk);
      if (we) model[addr] = data_in;
      #1 check("rand_after", data_out, model[addr]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
